// File: rtl/pipe_regfile.sv
// Register file with busy-bit scoreboard for an in-order issue pipeline.
// Latency: reads, bypass and stall are combinational; writes, busy marks and busy_count update on the clock edge.
// Backpressure: stall blocks issue on RAW (unless bypassed) or WAW hazards; a stalled issue marks nothing busy.
module pipe_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_rd_use,
    input  logic              rs1_use,
    input  logic              rs2_use,
    input  logic              flush,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    localparam int   DEPTH   = 2 ** ADDR_W;
    localparam logic LP_ZERO = (ZERO_REG != 0);
    localparam logic LP_BYP  = (BYPASS != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;

    // ------------------------------------------------------------------
    // Address qualifiers: register 0 is hardwired when ZERO_REG is set
    // ------------------------------------------------------------------
    logic w_rs1_zero;
    logic w_rs2_zero;
    logic w_wr_zero;
    logic w_rd_zero;

    assign w_rs1_zero = LP_ZERO && (rs1_addr == '0);
    assign w_rs2_zero = LP_ZERO && (rs2_addr == '0);
    assign w_wr_zero  = LP_ZERO && (wr_addr  == '0);
    assign w_rd_zero  = LP_ZERO && (issue_rd == '0);

    // ------------------------------------------------------------------
    // Write-back and forwarding
    // ------------------------------------------------------------------
    logic w_wr_en;
    logic w_byp1;
    logic w_byp2;

    assign w_wr_en = we && !w_wr_zero;
    assign w_byp1  = LP_BYP && we && (wr_addr == rs1_addr) && !w_rs1_zero;
    assign w_byp2  = LP_BYP && we && (wr_addr == rs2_addr) && !w_rs2_zero;

    // Read mux: zero register first, then same-cycle forward, then stored value
    always_comb begin
        rd1_data = r_regs[rs1_addr];
        rd2_data = r_regs[rs2_addr];
        if (w_byp1)     rd1_data = wr_data;
        if (w_byp2)     rd2_data = wr_data;
        if (w_rs1_zero) rd1_data = '0;
        if (w_rs2_zero) rd2_data = '0;
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_haz1;
    logic w_haz2;
    logic w_waw;
    logic w_stall;

    // A forwarded operand is not a hazard; without forwarding the reader
    // waits one cycle until the value has landed in the array.
    assign w_haz1 = rs1_use && r_busy[rs1_addr] && !w_byp1 && !w_rs1_zero;
    assign w_haz2 = rs2_use && r_busy[rs2_addr] && !w_byp2 && !w_rs2_zero;

    // A destination still owed by an older writer blocks issue unless that
    // writer retires on this very edge.
    assign w_waw  = issue_rd_use && r_busy[issue_rd] &&
                    !(we && (wr_addr == issue_rd));

    assign w_stall = !reset && issue_valid && (w_haz1 || w_haz2 || w_waw);
    assign stall   = w_stall;

    // ------------------------------------------------------------------
    // Busy-vector update
    // ------------------------------------------------------------------
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]  w_count_nxt;

    assign w_set = issue_valid && !w_stall && issue_rd_use && !flush && !w_rd_zero;
    assign w_clr = w_wr_en;

    // Count moves only when a bit actually changes; a set and clear on the
    // same address nets to "set", so the clear is not counted then.
    assign w_inc = w_set && !r_busy[issue_rd];
    assign w_dec = w_clr && r_busy[wr_addr] && !(w_set && (issue_rd == wr_addr));

    // Next busy vector: clear, then set (set wins), then flush overrides all
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[wr_addr]  = 1'b0;
        if (w_set) w_busy_nxt[issue_rd] = 1'b1;
        if (flush) w_busy_nxt           = '0;
    end

    // Next busy count tracks the population of the next busy vector
    always_comb begin
        w_count_nxt = r_busy_count;
        if (w_inc) w_count_nxt = w_count_nxt + {{ADDR_W{1'b0}}, 1'b1};
        if (w_dec) w_count_nxt = w_count_nxt - {{ADDR_W{1'b0}}, 1'b1};
        if (flush) w_count_nxt = '0;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Register array: cleared by reset, written on retire (flush does not block it)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Busy bits and their running population count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
        end
    end

    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: one forwarding instance and one without,
// sharing all stimulus; expected values are queued as stimulus is applied
// and popped when the corresponding output is sampled.
module tb_pipe_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [DW-1:0] wr_data;
    logic          we, issue_valid, issue_rd_use, rs1_use, rs2_use, flush;

    logic [DW-1:0] rd1_data, rd2_data, nb_rd1_data, nb_rd2_data;
    logic          stall, nb_stall;
    logic [AW:0]   busy_count, nb_busy_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;
    sb_t sb_q[$];

    always #5 clock = ~clock;

    pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_use(issue_rd_use),
        .rs1_use(rs1_use), .rs2_use(rs2_use), .flush(flush),
        .stall(stall), .busy_count(busy_count)
    );

    pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(nb_rd1_data), .rd2_data(nb_rd2_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_use(issue_rd_use),
        .rs1_use(rs1_use), .rs2_use(rs2_use), .flush(flush),
        .stall(nb_stall), .busy_count(nb_busy_count)
    );

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_chk(input logic [31:0] obs);
        sb_t e;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %h with no expected value queued", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Step to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; we = 0; wr_addr = 0; wr_data = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_use = 0; rs2_use = 0;
        issue_valid = 0; issue_rd = 0; issue_rd_use = 0; flush = 0;

        // Reset state
        #3;
        sb_push("rst_rd1", 0); sb_push("rst_rd2", 0);
        sb_push("rst_stall", 0); sb_push("rst_cnt", 0); sb_push("rst_nb_cnt", 0);
        sb_chk(rd1_data); sb_chk(rd2_data); sb_chk(stall);
        sb_chk({26'b0, busy_count}); sb_chk({26'b0, nb_busy_count});
        @(negedge clock);
        reset = 1'b0;

        // Write 0xDEADBEEF to r5: forwarded same cycle only with bypass
        tick();
        we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5; rs2_addr = 5;
        sb_push("wr5_byp_rd1", 32'hDEADBEEF); sb_push("wr5_nobyp_rd1", 0);
        #1; sb_chk(rd1_data); sb_chk(nb_rd1_data);
        tick();
        we = 0;
        sb_push("r5_rd1", 32'hDEADBEEF); sb_push("r5_rd2", 32'hDEADBEEF);
        sb_push("r5_nb_rd2", 32'hDEADBEEF);
        #1; sb_chk(rd1_data); sb_chk(rd2_data); sb_chk(nb_rd2_data);

        // RAW on r3
        tick();
        issue_valid = 1; issue_rd = 3; issue_rd_use = 1;
        sb_push("iss3_stall", 0);
        #1; sb_chk(stall);
        tick();
        issue_rd_use = 0; rs1_addr = 3; rs1_use = 1;
        sb_push("raw3_stall", 1); sb_push("raw3_nb_stall", 1); sb_push("raw3_cnt", 1);
        #1; sb_chk(stall); sb_chk(nb_stall); sb_chk({26'b0, busy_count});
        we = 1; wr_addr = 3; wr_data = 32'h11;
        sb_push("raw3_wb_stall", 0); sb_push("raw3_wb_rd1", 32'h11);
        sb_push("raw3_wb_nb_stall", 1);
        #1; sb_chk(stall); sb_chk(rd1_data); sb_chk(nb_stall);
        tick();
        we = 0;
        sb_push("raw3_next_nb_stall", 0); sb_push("raw3_next_nb_rd1", 32'h11);
        sb_push("raw3_next_cnt", 0); sb_push("raw3_next_nb_cnt", 0);
        #1; sb_chk(nb_stall); sb_chk(nb_rd1_data);
        sb_chk({26'b0, busy_count}); sb_chk({26'b0, nb_busy_count});

        // Register 0 is hardwired: no write, no forward, no busy mark
        tick();
        we = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rs1_addr = 0; rs1_use = 1;
        issue_rd = 0; issue_rd_use = 1;
        sb_push("r0_wr_rd1", 0); sb_push("r0_wr_stall", 0);
        #1; sb_chk(rd1_data); sb_chk(stall);
        tick();
        we = 0; issue_rd_use = 0;
        sb_push("r0_rd1", 0); sb_push("r0_stall", 0); sb_push("r0_cnt", 0);
        #1; sb_chk(rd1_data); sb_chk(stall); sb_chk({26'b0, busy_count});

        // Issue rd=7 with a write to r7 on the same edge: set wins
        tick();
        rs1_use = 0; issue_rd = 7; issue_rd_use = 1;
        we = 1; wr_addr = 7; wr_data = 32'h77;
        sb_push("setclr7_stall", 0);
        #1; sb_chk(stall);
        tick();
        we = 0; issue_rd_use = 0; rs1_addr = 7; rs1_use = 1;
        sb_push("setclr7_cnt", 1); sb_push("setclr7_stall_rd", 1);
        sb_push("setclr7_nb_stall_rd", 1); sb_push("setclr7_rd1", 32'h77);
        #1; sb_chk({26'b0, busy_count}); sb_chk(stall); sb_chk(nb_stall); sb_chk(rd1_data);

        // WAW on r7, released by a same-cycle retire of r7
        rs1_use = 0; issue_rd_use = 1;
        sb_push("waw7_stall", 1);
        #1; sb_chk(stall);
        we = 1; wr_addr = 7; wr_data = 32'h78;
        sb_push("waw7_wb_stall", 0); sb_push("waw7_wb_nb_stall", 0);
        #1; sb_chk(stall); sb_chk(nb_stall);
        tick();
        we = 0; issue_rd_use = 0; rs1_use = 1;
        sb_push("waw7_cnt", 1); sb_push("waw7_busy", 1); sb_push("waw7_rd1", 32'h78);
        #1; sb_chk({26'b0, busy_count}); sb_chk(stall); sb_chk(rd1_data);
        tick();
        rs1_use = 0; issue_valid = 0; we = 1; wr_addr = 7; wr_data = 32'h79;
        tick();
        we = 0;
        sb_push("clr7_cnt", 0);
        #1; sb_chk({26'b0, busy_count});

        // Mark r1, r2, r4 busy; WAW stall sets nothing; flush beats a set
        issue_valid = 1; issue_rd_use = 1; issue_rd = 1;
        tick();
        issue_rd = 2;
        tick();
        issue_rd = 4;
        tick();
        sb_push("three_cnt", 3);
        #1; sb_chk({26'b0, busy_count});
        issue_rd = 2;
        sb_push("waw2_stall", 1);
        #1; sb_chk(stall);
        tick();
        sb_push("waw2_cnt", 3);
        #1; sb_chk({26'b0, busy_count});
        flush = 1; issue_rd = 6; we = 1; wr_addr = 9; wr_data = 32'h99;
        sb_push("flush_stall", 0);
        #1; sb_chk(stall);
        tick();
        flush = 0; we = 0; issue_rd_use = 0;
        rs1_addr = 6; rs1_use = 1; rs2_addr = 9; rs2_use = 1;
        sb_push("flush_cnt", 0); sb_push("flush_r6_stall", 0); sb_push("flush_wr9", 32'h99);
        #1; sb_chk({26'b0, busy_count}); sb_chk(stall); sb_chk(rd2_data);

        // Asynchronous reset between edges
        tick();
        rs1_use = 0; rs2_use = 0; issue_rd = 10; issue_rd_use = 1;
        tick();
        issue_rd_use = 0; rs1_addr = 10; rs1_use = 1; rs2_addr = 5;
        sb_push("pre_rst_stall", 1); sb_push("pre_rst_cnt", 1); sb_push("pre_rst_rd2", 32'hDEADBEEF);
        #1; sb_chk(stall); sb_chk({26'b0, busy_count}); sb_chk(rd2_data);
        reset = 1;
        sb_push("arst_stall", 0); sb_push("arst_cnt", 0); sb_push("arst_rd2", 0);
        sb_push("arst_nb_rd2", 0); sb_push("arst_nb_cnt", 0);
        #1; sb_chk(stall); sb_chk({26'b0, busy_count}); sb_chk(rd2_data);
        sb_chk(nb_rd2_data); sb_chk({26'b0, nb_busy_count});
        @(negedge clock);
        reset = 0; issue_valid = 0; rs1_use = 0;
        we = 1; wr_addr = 12; wr_data = 32'h5A; rs1_addr = 12;
        tick();
        we = 0;
        sb_push("post_rst_rd1", 32'h5A); sb_push("post_rst_nb_rd1", 32'h5A);
        sb_push("post_rst_cnt", 0);
        #1; sb_chk(rd1_data); sb_chk(nb_rd1_data); sb_chk({26'b0, busy_count});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
